// File: rtl/ram16_arbiter.sv
// Round-robin arbiter/sequencer between two valid/ready requesters and the single-port RAM16 store.
// Each accepted command is issued as one RAM strobe; reads and write acks return on a response pulse.
module ram16_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [15:0]           req0_wdata,
    output logic                  rsp0_valid,
    output logic [15:0]           rsp0_rdata,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [15:0]           req1_wdata,
    output logic                  rsp1_valid,
    output logic [15:0]           rsp1_rdata,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [15:0]           ram_din,
    input  logic [15:0]           ram_dout,
    output logic                  busy
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic             we_p0;
    logic             id_p0;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant0, grant1, accept, rsp_fire;

    // last_grant names the requester served most recently; the other one wins a tie.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && (!req0_valid || !last_grant);
        req0_ready = rst && (state == IDLE) && grant0;
        req1_ready = rst && (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
    end

    always_comb begin
        state_nxt = state;
        ram_write = 1'b0;
        ram_read  = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE: begin
                ram_write = we_p0;
                ram_read  = !we_p0;
                rsp_fire  = we_p0;
                state_nxt = we_p0 ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    rsp_fire  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            we_p0      <= 1'b0;
            id_p0      <= 1'b0;
            wait_cnt   <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
        end else begin
            state      <= state_nxt;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            wait_cnt   <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            // Accept stage: the command latch doubles as the RAM address/data registers.
            if (accept) begin
                we_p0      <= req1_ready ? req1_we : req0_we;
                id_p0      <= req1_ready;
                last_grant <= req1_ready;
                ram_addr   <= req1_ready ? req1_addr : req0_addr;
                ram_din    <= req1_ready ? req1_wdata : req0_wdata;
            end
            // Response stage: write ack carries zero, a read carries the sampled RAM word.
            if (rsp_fire) begin
                if (id_p0) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= we_p0 ? 16'h0000 : ram_dout;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= we_p0 ? 16'h0000 : ram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram16_arbiter.sv
// Directed bench for ram16_arbiter: RD_LATENCY=1 instance with a RAM model, plus an RD_LATENCY=3 instance.
module tb_ram16_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req0_we, rsp0_valid;
    logic [2:0]  req0_addr;
    logic [15:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, rsp1_valid;
    logic [2:0]  req1_addr;
    logic [15:0] req1_wdata, rsp1_rdata;
    logic        ram_read, ram_write, busy;
    logic [2:0]  ram_addr;
    logic [15:0] ram_din, ram_dout;

    logic        l3_req0_valid, l3_req0_ready, l3_req0_we, l3_rsp0_valid;
    logic [2:0]  l3_req0_addr;
    logic [15:0] l3_req0_wdata, l3_rsp0_rdata;
    logic        l3_req1_valid, l3_req1_ready, l3_req1_we, l3_rsp1_valid;
    logic [2:0]  l3_req1_addr;
    logic [15:0] l3_req1_wdata, l3_rsp1_rdata;
    logic        l3_ram_read, l3_ram_write, l3_busy;
    logic [2:0]  l3_ram_addr;
    logic [15:0] l3_ram_din, l3_ram_dout;

    ram16_arbiter #(.ADDR_WIDTH(3), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
    );

    ram16_arbiter #(.ADDR_WIDTH(3), .RD_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_we(l3_req0_we),
        .req0_addr(l3_req0_addr), .req0_wdata(l3_req0_wdata),
        .rsp0_valid(l3_rsp0_valid), .rsp0_rdata(l3_rsp0_rdata),
        .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_we(l3_req1_we),
        .req1_addr(l3_req1_addr), .req1_wdata(l3_req1_wdata),
        .rsp1_valid(l3_rsp1_valid), .rsp1_rdata(l3_rsp1_rdata),
        .ram_read(l3_ram_read), .ram_write(l3_ram_write), .ram_addr(l3_ram_addr),
        .ram_din(l3_ram_din), .ram_dout(l3_ram_dout), .busy(l3_busy)
    );

    // RAM models: one-cycle store for the main instance, three-stage read-only pattern for the other.
    logic [15:0] mem1 [8];
    logic [15:0] d3_a, d3_b;
    always @(posedge clk) begin
        if (ram_write) mem1[ram_addr] <= ram_din;
        ram_dout <= ram_read ? mem1[ram_addr] : 16'h0BAD;
    end
    always @(posedge clk) begin
        d3_a        <= l3_ram_read ? (16'h5A00 | 16'(l3_ram_addr)) : 16'h0BAD;
        d3_b        <= d3_a;
        l3_ram_dout <= d3_b;
    end

    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_ovl = 0, n_rsp0 = 0, n_rsp1 = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ram_write) n_wr <= n_wr + 1;
        if (ram_read) n_rd <= n_rd + 1;
        if (ram_write && ram_read) n_ovl <= n_ovl + 1;
        if (rsp0_valid) n_rsp0 <= n_rsp0 + 1;
        if (rsp1_valid) n_rsp1 <= n_rsp1 + 1;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          req;
        bit          we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tbl [26];

    task automatic run_cmd(input vec_t v, input string tag);
        int t_acc, lat, wr0, rd0;
        bit got;
        logic [15:0] rd;
        t_acc = 0; lat = 0; wr0 = 0; rd0 = 0; got = 0; rd = '0;
        @(negedge clk);
        if (v.req) begin
            req1_valid = 1'b1; req1_we = v.we; req1_addr = v.addr; req1_wdata = v.wdata;
        end else begin
            req0_valid = 1'b1; req0_we = v.we; req0_addr = v.addr; req0_wdata = v.wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (v.req ? req1_ready : req0_ready) begin
                got = 1'b1; t_acc = cyc; wr0 = n_wr; rd0 = n_rd;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_accept"}, 64'(got), 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (v.req ? rsp1_valid : rsp0_valid) begin
                got = 1'b1; lat = cyc - t_acc; rd = v.req ? rsp1_rdata : rsp0_rdata;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_rsp_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rdata));
        @(negedge clk);
        #1;
        check({tag, "_rsp_one_cycle"}, 64'(v.req ? rsp1_valid : rsp0_valid), 64'd0);
        check({tag, "_ram_writes"}, 64'(n_wr - wr0), 64'(v.we));
        check({tag, "_ram_reads"}, 64'(n_rd - rd0), 64'(!v.we));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_wr, s_rd, s0, s1, n0, n1, k, t_acc, lat, busy_bad;
        bit r0, r1, got;
        logic [15:0] order;
        logic [1:0]  first;

        rst = 1'b0;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        l3_req0_valid = 0; l3_req0_we = 0; l3_req0_addr = '0; l3_req0_wdata = '0;
        l3_req1_valid = 0; l3_req1_we = 0; l3_req1_addr = '0; l3_req1_wdata = '0;

        tbl[0] = '{req: 1'b0, we: 1'b1, addr: 3'd3, wdata: 16'hB003, exp_rdata: 16'h0000, exp_lat: 2};
        tbl[1] = '{req: 1'b0, we: 1'b0, addr: 3'd3, wdata: 16'h0000, exp_rdata: 16'hB003, exp_lat: 3};
        for (int i = 0; i < 16; i++) begin
            tbl[2+i] = '{req: 1'b1, we: 1'b1, addr: 3'(i % 8), wdata: 16'(16'hB000 + i),
                         exp_rdata: 16'h0000, exp_lat: 2};
        end
        for (int a = 0; a < 8; a++) begin
            tbl[18+a] = '{req: 1'(a % 2), we: 1'b0, addr: 3'(a), wdata: 16'h0000,
                          exp_rdata: 16'(16'hB008 + a), exp_lat: 3};
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
                                    ram_read, ram_write, ram_addr, ram_din, busy}), 64'd0);
        check("reset_outputs_lat3", 64'({l3_req0_ready, l3_req1_ready, l3_rsp0_valid, l3_rsp1_valid,
                                         l3_rsp0_rdata, l3_rsp1_rdata, l3_ram_read, l3_ram_write,
                                         l3_ram_addr, l3_ram_din, l3_busy}), 64'd0);
        rst = 1'b1;

        // Reset in the middle of a read: the access is dropped without a response.
        @(negedge clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd2;
        #1;
        check("midread_accept", 64'(req0_ready), 64'd1);
        s0 = n_rsp0;
        @(negedge clk);
        req0_valid = 1'b0;
        check("midread_issue", 64'({ram_read, ram_addr}), 64'({1'b1, 3'd2}));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_outputs", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
                                       ram_read, ram_write, ram_addr, ram_din, busy}), 64'd0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("midreset_no_rsp0", 64'(n_rsp0 - s0), 64'd0);

        // Both requesters valid every cycle: req0 reads, req1 writes, grants must alternate from req0.
        @(negedge clk);
        s_wr = n_wr; s_rd = n_rd; s0 = n_rsp0; s1 = n_rsp1;
        n0 = 0; n1 = 0; k = 0; order = '0; first = '0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 3'd0;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 3'd0; req1_wdata = 16'hC000;
        for (int c = 0; c < 300 && (n0 < 8 || n1 < 8); c++) begin
            #1;
            r0 = req0_ready; r1 = req1_ready;
            if (r0 || r1) begin
                if (k == 0) first = {r0, r1};
                if (k < 16) order[k] = r1;
                k++;
            end
            if (r0) n0++;
            if (r1) n1++;
            @(negedge clk);
            if (r0) begin req0_valid = (n0 < 8); req0_addr = 3'(n0); end
            if (r1) begin req1_valid = (n1 < 8); req1_addr = 3'(n1); req1_wdata = 16'(16'hC000 + n1); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("post_reset_first_grant", 64'(first), 64'b10);
        check("contention_grant_count", 64'(k), 64'd16);
        check("contention_grant_order", 64'(order), 64'hAAAA);
        check("contention_rsp0", 64'(n_rsp0 - s0), 64'd8);
        check("contention_rsp1", 64'(n_rsp1 - s1), 64'd8);
        check("contention_strobes", 64'({16'(n_wr - s_wr), 16'(n_rd - s_rd)}), 64'({16'd8, 16'd8}));
        check("no_strobe_overlap", 64'(n_ovl), 64'd0);

        for (int v = 0; v < 26; v++) run_cmd(tbl[v], $sformatf("vec%0d", v));

        // req0 pulses valid for a single cycle while req1's read is in flight.
        @(negedge clk);
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 3'd4;
        #1;
        s_wr = n_wr; s_rd = n_rd; s0 = n_rsp0; s1 = n_rsp1;
        check("pulse_req1_accept", 64'(req1_ready), 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 3'd6; req0_wdata = 16'hFFFF;
        #1;
        check("pulse_req0_blocked", 64'(req0_ready), 64'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("pulse_ram_writes", 64'(n_wr - s_wr), 64'd0);
        check("pulse_ram_reads", 64'(n_rd - s_rd), 64'd1);
        check("pulse_no_rsp0", 64'(n_rsp0 - s0), 64'd0);
        check("pulse_rsp1", 64'(n_rsp1 - s1), 64'd1);
        check("pulse_rsp1_rdata", 64'(rsp1_rdata), 64'hB00C);
        check("pulse_mem6_kept", 64'(mem1[6]), 64'hB00E);

        // RD_LATENCY=3 instance: read addr 5 answers at accept+5 with busy held throughout.
        @(negedge clk);
        l3_req0_valid = 1'b1; l3_req0_we = 1'b0; l3_req0_addr = 3'd5;
        #1;
        check("lat3_accept", 64'(l3_req0_ready), 64'd1);
        t_acc = cyc;
        @(negedge clk);
        l3_req0_valid = 1'b0;
        got = 1'b0; busy_bad = 0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (!l3_busy) busy_bad++;
            if (l3_rsp0_valid) begin
                got = 1'b1; lat = cyc - t_acc;
            end else begin
                @(negedge clk);
            end
        end
        check("lat3_rsp_seen", 64'(got), 64'd1);
        check("lat3_latency", 64'(lat), 64'd5);
        check("lat3_rdata", 64'(l3_rsp0_rdata), 64'h5A05);
        check("lat3_busy_throughout", 64'(busy_bad), 64'd0);
        @(negedge clk);
        check("lat3_idle_after", 64'({l3_busy, l3_rsp0_valid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
